// File: rtl/wb_fifo_pkg.sv
// rtl/wb_fifo_pkg.sv - shared pointer-width helper, reset values and status-bit indices for wb FIFOs
package wb_fifo_pkg;

  function automatic int ptr_w(input int lgflen);
    return lgflen + 1;
  endfunction

  localparam logic RST_EMPTY_N = 1'b0;
  localparam logic RST_FULL    = 1'b0;
  localparam logic RST_OVFL    = 1'b0;
  localparam logic RST_UNFL    = 1'b0;
  localparam logic RST_AFULL   = 1'b0;
  localparam logic RST_AEMPTY  = 1'b1;

  // Bit positions of {o_ovfl,o_unfl,o_full,o_empty_n} in a packed bus status word
  localparam int STAT_EMPTY_N = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_UNFL    = 2;
  localparam int STAT_OVFL    = 3;
  localparam int STAT_W       = 4;

endpackage

// File: rtl/wb_fifo_ram.sv
// rtl/wb_fifo_ram.sv - simple dual-port RAM, one write port and one registered read port (read-old on collision)
module wb_fifo_ram #(
  parameter int BW = 36,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [BW-1:0] rdata
);

  logic [BW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/wb_sync_fifo.sv
// rtl/wb_sync_fifo.sv - full-depth single-clock FIFO with sticky error flags
// Optional fill level / almost flags under WB_SYNC_FIFO_LEVEL_EN.
module wb_sync_fifo
  import wb_fifo_pkg::*;
#(
  parameter int BW     = 36,
  parameter int LGFLEN = 10,
  parameter int AF_LVL = (1 << LGFLEN) - 4,
  parameter int AE_LVL = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_empty_n,
  output logic              o_full,
  input  logic              i_clr_err,
  output logic              o_ovfl,
`ifdef WB_SYNC_FIFO_LEVEL_EN
  output logic [LGFLEN:0]   o_fill,
  output logic              o_afull,
  output logic              o_aempty,
`endif
  output logic              o_unfl
);

  localparam int PW = ptr_w(LGFLEN);
  localparam logic [PW-1:0] FLEN = {1'b1, {LGFLEN{1'b0}}};

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx, fill_nx;
  logic          wr_acc, rd_acc, byp, sel_byp;
  logic [BW-1:0] byp_data, ram_q;

  always_comb begin
    rd_acc    = i_rd && o_empty_n;
    wr_acc    = i_wr && (!o_full || i_rd);
    wr_ptr_nx = wr_ptr + {{LGFLEN{1'b0}}, wr_acc};
    rd_ptr_nx = rd_ptr + {{LGFLEN{1'b0}}, rd_acc};
    fill_nx   = wr_ptr_nx - rd_ptr_nx;
    // The RAM returns the old word when the new head is written this very edge
    byp       = wr_acc && (wr_ptr[LGFLEN-1:0] == rd_ptr_nx[LGFLEN-1:0]);
  end

  wb_fifo_ram #(.BW(BW), .AW(LGFLEN)) u_ram (
    .clk   (i_clk),
    .we    (wr_acc && i_rst_n),
    .waddr (wr_ptr[LGFLEN-1:0]),
    .wdata (i_data),
    .raddr (rd_ptr_nx[LGFLEN-1:0]),
    .rdata (ram_q)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_empty_n <= RST_EMPTY_N;
      o_full    <= RST_FULL;
      o_ovfl    <= RST_OVFL;
      o_unfl    <= RST_UNFL;
      sel_byp   <= 1'b1;
      byp_data  <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nx;
      rd_ptr    <= rd_ptr_nx;
      o_empty_n <= (fill_nx != '0);
      o_full    <= (fill_nx == FLEN);
      o_ovfl    <= (i_wr && !wr_acc) || (o_ovfl && !i_clr_err);
      o_unfl    <= (i_rd && !rd_acc) || (o_unfl && !i_clr_err);
      // Held bypass word stays the head until it is popped
      if (byp) begin
        sel_byp  <= 1'b1;
        byp_data <= i_data;
      end else if (rd_acc) begin
        sel_byp  <= 1'b0;
      end
    end
  end

  assign o_data = sel_byp ? byp_data : ram_q;

`ifdef WB_SYNC_FIFO_LEVEL_EN
  localparam logic [PW-1:0] AF = PW'(AF_LVL);
  localparam logic [PW-1:0] AE = PW'(AE_LVL);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_fill   <= '0;
      o_afull  <= RST_AFULL;
      o_aempty <= RST_AEMPTY;
    end else begin
      o_fill   <= fill_nx;
      o_afull  <= (fill_nx >= AF);
      o_aempty <= (fill_nx <= AE);
    end
  end
`endif

endmodule

// File: tb/tb_wb_sync_fifo.sv
// tb/tb_wb_sync_fifo.sv - randomized and directed self-checking bench for wb_sync_fifo
module tb_wb_sync_fifo;

  localparam int FLEN = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [35:0] wdata = '0;
  logic [35:0] data;
  logic        empty_n, full, ovfl, unfl;
`ifdef WB_SYNC_FIFO_LEVEL_EN
  logic [4:0]  fill;
  logic        afull, aempty;
`endif

  logic        s_rst_n = 1'b0, s_wr = 1'b0, s_rd = 1'b0;
  logic [7:0]  s_wdata = '0;
  logic [7:0]  s_data;
  logic        s_empty_n, s_full, s_ovfl, s_unfl;
`ifdef WB_SYNC_FIFO_LEVEL_EN
  logic [2:0]  s_fill;
  logic        s_afull, s_aempty;
`endif

  int checks = 0;
  int errors = 0;

  logic [35:0] m_q[$];
  logic        m_ovfl = 1'b0, m_unfl = 1'b0;
  logic [35:0] m_data = '0;

  always #5 clk = ~clk;

  wb_sync_fifo #(.BW(36), .LGFLEN(4), .AF_LVL(12), .AE_LVL(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_data(wdata), .i_rd(rd),
    .o_data(data), .o_empty_n(empty_n), .o_full(full), .i_clr_err(clr),
    .o_ovfl(ovfl),
`ifdef WB_SYNC_FIFO_LEVEL_EN
    .o_fill(fill), .o_afull(afull), .o_aempty(aempty),
`endif
    .o_unfl(unfl)
  );

  wb_sync_fifo #(.BW(8), .LGFLEN(2), .AF_LVL(3), .AE_LVL(1)) dut_s (
    .i_clk(clk), .i_rst_n(s_rst_n), .i_wr(s_wr), .i_data(s_wdata), .i_rd(s_rd),
    .o_data(s_data), .o_empty_n(s_empty_n), .o_full(s_full), .i_clr_err(1'b0),
    .o_ovfl(s_ovfl),
`ifdef WB_SYNC_FIFO_LEVEL_EN
    .o_fill(s_fill), .o_afull(s_afull), .o_aempty(s_aempty),
`endif
    .o_unfl(s_unfl)
  );

  // Drives one cycle and advances the queue model by the FIFO's accept rules
  task automatic step(input logic r, input logic w, input logic [35:0] d,
                      input logic p, input logic c);
    bit rd_ok, wr_ok;
    rst_n = r; wr = w; wdata = d; rd = p; clr = c;
    @(posedge clk);
    if (!r) begin
      m_q.delete();
      m_ovfl = 1'b0;
      m_unfl = 1'b0;
      m_data = '0;
    end else begin
      rd_ok = p && (m_q.size() > 0);
      wr_ok = w && ((m_q.size() < FLEN) || p);
      m_ovfl = (w && !wr_ok) || (m_ovfl && !c);
      m_unfl = (p && !rd_ok) || (m_unfl && !c);
      if (rd_ok) void'(m_q.pop_front());
      if (wr_ok) m_q.push_back(d);
      if (m_q.size() > 0) m_data = m_q[0];
    end
    #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0; rst_n = 1'b1;
  endtask

  task automatic s_step(input logic r, input logic w, input logic [7:0] d, input logic p);
    s_rst_n = r; s_wr = w; s_wdata = d; s_rd = p;
    @(posedge clk);
    #1;
    s_wr = 1'b0; s_rd = 1'b0; s_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 36'h5, 1'b1, 1'b0);
    checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL reset_empty_n got %b want 0", empty_n); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (data !== 36'h0) begin errors++; $display("FAIL reset_data got %h want 0", data); end
    checks++; if ({ovfl, unfl} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {ovfl, unfl}); end
`ifdef WB_SYNC_FIFO_LEVEL_EN
    checks++; if ({fill, afull, aempty} !== {5'd0, 1'b0, 1'b1}) begin errors++;
      $display("FAIL reset_level got %0d/%b/%b want 0/0/1", fill, afull, aempty); end
`endif
  endtask

  task automatic test_basic();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 36'h1, 1'b0, 1'b0);
    checks++; if (empty_n !== 1'b1 || data !== 36'h1) begin errors++;
      $display("FAIL basic_first got empty_n=%b data=%h want 1/1", empty_n, data); end
    step(1'b1, 1'b1, 36'h2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 36'h3, 1'b0, 1'b0);
    checks++; if (data !== 36'h1) begin errors++; $display("FAIL basic_head got %h want 1", data); end
`ifdef WB_SYNC_FIFO_LEVEL_EN
    checks++; if (fill !== 5'd3) begin errors++; $display("FAIL basic_fill got %0d want 3", fill); end
`endif
  endtask

  task automatic test_small_overflow();
    logic [7:0] exp;
    s_step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      s_step(1'b1, 1'b1, 8'hA + 8'(i), 1'b0);
      if (i == 3) begin
        checks++; if (s_full !== 1'b1 || s_ovfl !== 1'b0) begin errors++;
          $display("FAIL small_full got full=%b ovfl=%b want 1/0", s_full, s_ovfl); end
      end
    end
    checks++; if (s_ovfl !== 1'b1 || s_full !== 1'b1) begin errors++;
      $display("FAIL small_ovfl got ovfl=%b full=%b want 1/1", s_ovfl, s_full); end
    for (int i = 0; i < 4; i++) begin
      exp = 8'hA + 8'(i);
      checks++; if (s_data !== exp || s_empty_n !== 1'b1) begin errors++;
        $display("FAIL small_drain%0d got %h/%b want %h/1", i, s_data, s_empty_n, exp); end
      s_step(1'b1, 1'b0, '0, 1'b1);
    end
    checks++; if (s_empty_n !== 1'b0) begin errors++; $display("FAIL small_empty got %b want 0", s_empty_n); end
  endtask

  task automatic test_full_rdwr();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < FLEN; i++) step(1'b1, 1'b1, {$urandom, 4'h0}, 1'b0, 1'b0);
    for (int i = 0; i < 2 * FLEN; i++) begin
      step(1'b1, 1'b1, 36'h55, 1'b1, 1'b0);
      checks++; if (full !== 1'b1 || ovfl !== 1'b0 || data !== m_data) begin errors++;
        $display("FAIL full_rdwr%0d got full=%b ovfl=%b data=%h want 1/0/%h", i, full, ovfl, data, m_data); end
    end
  endtask

  task automatic test_empty_rdwr();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 36'h77, 1'b1, 1'b0);
    checks++; if (unfl !== 1'b1 || empty_n !== 1'b1 || data !== 36'h77) begin errors++;
      $display("FAIL empty_rdwr got unfl=%b empty_n=%b data=%h want 1/1/77", unfl, empty_n, data); end
  endtask

  task automatic test_clr_err();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < FLEN; i++) step(1'b1, 1'b1, 36'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 36'h99, 1'b0, 1'b0);
    checks++; if (ovfl !== 1'b1) begin errors++; $display("FAIL clr_set got %b want 1", ovfl); end
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    checks++; if (ovfl !== 1'b0) begin errors++; $display("FAIL clr_clear got %b want 0", ovfl); end
    step(1'b1, 1'b1, 36'h99, 1'b0, 1'b0);
    step(1'b1, 1'b1, 36'h98, 1'b0, 1'b1);
    checks++; if (ovfl !== 1'b1 || data !== 36'h0) begin errors++;
      $display("FAIL clr_refuse_wins got ovfl=%b data=%h want 1/0", ovfl, data); end
  endtask

  task automatic test_levels();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int n = 1; n <= FLEN; n++) begin
      step(1'b1, 1'b1, 36'(n), 1'b0, 1'b0);
`ifdef WB_SYNC_FIFO_LEVEL_EN
      checks++; if (fill !== 5'(n) || aempty !== (n <= 4) || afull !== (n >= 12)) begin errors++;
        $display("FAIL level_fill%0d got %0d/%b/%b want %0d/%b/%b", n, fill, aempty, afull, n, n <= 4, n >= 12); end
`endif
    end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 36'h3, 1'b1, 1'b0);
    checks++; if ({empty_n, full, ovfl, unfl} !== 4'b0000 || data !== 36'h0) begin errors++;
      $display("FAIL level_midreset got flags=%b data=%h want 0000/0", {empty_n, full, ovfl, unfl}, data); end
`ifdef WB_SYNC_FIFO_LEVEL_EN
    checks++; if ({fill, afull, aempty} !== {5'd0, 1'b0, 1'b1}) begin errors++;
      $display("FAIL level_midreset_lvl got %0d/%b/%b want 0/0/1", fill, afull, aempty); end
`endif
  endtask

  task automatic test_random();
    logic r, w, p, c;
    int n;
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(99) >= 2);
      w = ($urandom_range(99) < ((i / 100) % 2 ? 70 : 40));
      p = ($urandom_range(99) < ((i / 100) % 2 ? 40 : 70));
      c = ($urandom_range(99) < 8);
      step(r, w, {$urandom, 4'($urandom)}, p, c);
      n = m_q.size();
      checks++; if ({empty_n, full, ovfl, unfl} !== {n != 0, n == FLEN, m_ovfl, m_unfl}) begin errors++;
        $display("FAIL rand_flags%0d got %b want %b", i, {empty_n, full, ovfl, unfl}, {n != 0, n == FLEN, m_ovfl, m_unfl}); end
      if (n != 0) begin
        checks++; if (data !== m_data) begin errors++; $display("FAIL rand_data%0d got %h want %h", i, data, m_data); end
      end
`ifdef WB_SYNC_FIFO_LEVEL_EN
      checks++; if (fill !== 5'(n) || afull !== (n >= 12) || aempty !== (n <= 4)) begin errors++;
        $display("FAIL rand_level%0d got %0d/%b/%b want %0d", i, fill, afull, aempty, n); end
`endif
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_small_overflow();
    test_full_rdwr();
    test_empty_rdwr();
    test_clr_err();
    test_levels();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
